// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and shared slow-memory signals around the arbiter.
interface mem_arbiter_if;
    // I-cache side
    logic         mem_read_I;
    logic         mem_write_I;
    logic [27:0]  mem_addr_I;
    logic [127:0] mem_wdata_I;
    logic [127:0] mem_rdata_I;
    logic         mem_ready_I;
    // D-cache side
    logic         mem_read_D;
    logic         mem_write_D;
    logic [27:0]  mem_addr_D;
    logic [127:0] mem_wdata_D;
    logic [127:0] mem_rdata_D;
    logic         mem_ready_D;
    // Shared slow memory side
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    // Arbiter view: client requests and memory responses come in
    modport slave (
        input  mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        input  mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        input  mem_rdata, mem_ready,
        output mem_rdata_I, mem_ready_I, mem_rdata_D, mem_ready_D,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment view: caches and memory drive the arbiter
    modport master (
        output mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        output mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        output mem_rdata, mem_ready,
        input  mem_rdata_I, mem_ready_I, mem_rdata_D, mem_ready_D,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of a single slow memory.
// One transaction at a time; every output is registered.
module mem_arbiter #(
    parameter bit RR = 1'b0
) (
    input  logic         clk,
    input  logic         proc_reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;
    typedef enum logic {CLI_I, CLI_D} client_t;

    state_t       state_q;
    client_t      last_grant_q;
    logic         mem_read_q;
    logic         mem_write_q;
    logic [27:0]  mem_addr_q;
    logic [127:0] mem_wdata_q;
    logic [127:0] rdata_i_q;
    logic [127:0] rdata_d_q;
    logic         ready_i_q;
    logic         ready_d_q;

    logic         req_i;
    logic         req_d;
    logic         sel_dside;

    // Request decode and the IDLE arbitration decision
    always_comb begin
        req_i     = bus.mem_read_I | bus.mem_write_I;
        req_d     = bus.mem_read_D | bus.mem_write_D;
        sel_dside = req_d && (!req_i || !RR || (last_grant_q == CLI_I));
    end

    // Grant FSM: capture the winner's request, wait for memory, pulse ready, cool down
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            last_grant_q <= CLI_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_i_q    <= '0;
            rdata_d_q    <= '0;
            ready_i_q    <= 1'b0;
            ready_d_q    <= 1'b0;
        end else begin
            ready_i_q <= 1'b0;
            ready_d_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_dside) begin
                        mem_read_q   <= bus.mem_read_D;
                        mem_write_q  <= bus.mem_write_D;
                        mem_addr_q   <= bus.mem_addr_D;
                        mem_wdata_q  <= bus.mem_wdata_D;
                        last_grant_q <= CLI_D;
                        state_q      <= GNT_D;
                    end else if (req_i) begin
                        mem_read_q   <= bus.mem_read_I;
                        mem_write_q  <= bus.mem_write_I;
                        mem_addr_q   <= bus.mem_addr_I;
                        mem_wdata_q  <= bus.mem_wdata_I;
                        last_grant_q <= CLI_I;
                        state_q      <= GNT_I;
                    end
                end
                GNT_I: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rdata_i_q   <= bus.mem_rdata;
                        ready_i_q   <= 1'b1;
                        state_q     <= RELEASE;
                    end
                end
                GNT_D: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rdata_d_q   <= bus.mem_rdata;
                        ready_d_q   <= 1'b1;
                        state_q     <= RELEASE;
                    end
                end
                // The finishing client still holds its request this cycle; skipping
                // arbitration here keeps it from being granted a second time.
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_rdata_I = rdata_i_q;
    assign bus.mem_ready_I = ready_i_q;
    assign bus.mem_rdata_D = rdata_d_q;
    assign bus.mem_ready_D = ready_d_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR, default 0: 0 = D-side fixed priority; 1 = round-robin between I and D.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 proc_reset  input  1  synchronous, active-high reset.
REQ-004 mem_read_I / mem_write_I  input  1 each  I-cache read/write request to slow memory.
REQ-005 mem_addr_I  input  28  I-cache line address, bits [31:4].
REQ-006 mem_wdata_I  input  128  I-cache write line.
REQ-007 mem_rdata_I  output  128  read line returned to I-cache.
REQ-008 mem_ready_I  output  1  one-cycle completion pulse to I-cache.
REQ-009 mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D, mem_rdata_D, mem_ready_D  D-cache equivalents of REQ-004..008.
REQ-010 mem_read / mem_write  output  1 each  request to the single shared slow memory.
REQ-011 mem_addr  output  28  shared memory line address.
REQ-012 mem_wdata  output  128  shared memory write line.
REQ-013 mem_rdata  input  128  shared memory read line.
REQ-014 mem_ready  input  1  shared memory completion; valid with mem_rdata for one cycle.

Function
REQ-015 States: IDLE, GNT_I, GNT_D, RELEASE; state register, last_grant bit, and all outputs are registered.
REQ-016 A client is requesting when its read or write is high. Client protocol: hold the request until ready is seen.
REQ-017 IDLE, no request: stay in IDLE; mem_read and mem_write are 0.
REQ-018 IDLE, one request: grant that client. The next cycle drives mem_read/mem_write/mem_addr/mem_wdata from the values captured at the grant edge.
REQ-019 IDLE, both request, RR=0: grant D.
REQ-020 IDLE, both request, RR=1: grant the client not in last_grant. last_grant updates at every grant.
REQ-021 GNT_x: hold captured mem_* outputs constant. Client input changes are ignored until completion.
REQ-022 GNT_x, mem_ready=1:
  - next cycle: mem_read=mem_write=0;
  - mem_rdata_x = captured mem_rdata;
  - mem_ready_x = 1 for exactly one cycle;
  - state goes to RELEASE.
REQ-023 RELEASE: lasts one cycle, ignores all requests, then goes to IDLE. The stale request of the finishing client is never re-granted.
REQ-024 Latency:
  - request in IDLE at cycle n -> memory request visible at n+1;
  - mem_ready at cycle m -> client ready at m+1;
  - earliest next grant evaluated at m+2.
REQ-025 The non-granted client sees ready=0 throughout, and its request is held pending.
REQ-026 A client asserting both read and write: forwarded unchanged. No error detection.
REQ-027 mem_rdata_I and mem_rdata_D hold their last captured value when not completing.
REQ-028 mem_ready while in IDLE or RELEASE is ignored; no ready pulse is generated.
REQ-029 Writes and reads are treated identically; the write completion pulse still updates the rdata register with mem_rdata.

Reset
REQ-030 proc_reset=1 forces, at the next edge:
  - state = IDLE;
  - last_grant = I;
  - mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0;
  - mem_ready_I = mem_ready_D = 0, mem_rdata_I = mem_rdata_D = 0.
REQ-031 Reset during GNT_x or RELEASE: abort without a ready pulse. The in-flight transaction is dropped, and clients re-request after reset.

Verification
REQ-032 Single I read: mem_read_I=1, addr_I=0x0000010, memory ready after 5 cycles with 0xDEAD...BEEF.
  - mem_read=1, addr=0x0000010 from n+1;
  - mem_ready_I pulses one cycle with that data;
  - mem_ready_D stays 0.
REQ-033 Simultaneous requests, RR=0: I reads 0x20 and D writes 0x30/0x55..55 at the same cycle.
  - D write served first, then I read;
  - exactly one ready pulse each;
  - mem_addr sequence 0x30 then 0x20.
REQ-034 RR=1, both clients hold requests across three transactions: grants alternate D, I, D (last_grant=I after reset). No starvation.
REQ-035 D-cache writeback then allocate: write 0x40, then read 0x80 issued the cycle after ready_D.
  - both served in order;
  - a pending I request waits until IDLE;
  - RELEASE never re-grants write 0x40.
REQ-036 Reset asserted two cycles into GNT_D: mem_read/mem_write 0 next cycle, no mem_ready_D pulse, state IDLE.
REQ-037 Spurious mem_ready in IDLE: no ready output pulse, no state change.
